sdrc_req_split: RTL and testbench
=================================

# sdrc_req_split

Parametrised request generator between the application request port and the bank controller. Each accepted request is buffered in a small queue, scaled to SDRAM beats according to the SDRAM data width, and split into bank-controller chunks. A chunk ends at the page boundary (non-wrap mode) or at a configurable maximum burst length, whichever comes first. Bank, row and column widths are parameters, and intake is decoupled from the bank handshake so the application can queue requests while a split burst is still in progress.

## Interface
Parameters:
- APP_AW, 30, application address width (application words)
- APP_RW, 9, application request length width (application words)
- REQ_BW, 12, chunk and remaining-length width in SDRAM beats; must be ≥ APP_RW+2
- ID_W, 4, request ID width
- BA_W, 2, bank address width
- RA_W, 13, row address width
- QDEPTH, 2, request queue depth (power of two, ≥1)
- CHUNK_MAX, 256, maximum beats per chunk (1..2^(REQ_BW-1))

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_colbits  in  2  column width = 8+cfg_colbits bits
- sdr_width  in  2  00 = 32-bit SDRAM, 01 = 16-bit, 1x = 8-bit
- req  in  1  application request
- req_id  in  ID_W  request ID
- req_addr  in  APP_AW  start address (application words)
- req_len  in  APP_RW  length (application words)
- req_wr_n  in  1  0 = write, 1 = read
- req_wrap  in  1  1 = wrap within page, no splitting
- req_ack  out  1  request accepted this cycle
- r2x_idle  out  1  block empty and no request pending
- r2b_req  out  1  chunk valid
- r2b_req_id  out  ID_W  ID of the parent request
- r2b_start, r2b_last  out  1 each  first / last chunk of the parent request
- r2b_wrap, r2b_write  out  1 each  wrap mode; 1 = write
- r2b_ba  out  BA_W  bank address
- r2b_raddr  out  RA_W  row address
- r2b_caddr  out  12  column address, zero-extended
- r2b_len  out  REQ_BW  chunk length (beats)
- b2r_ack  in  1  bank controller accepts the current chunk

## Operation
- **Intake:** req_ack = req & ~queue_full (combinational). On req_ack, the queue stores {id, addr, len, wr_n, wrap}.
- **Scaling at pop:**
  - Internal address = req_addr << s and length = req_len << s, where s = 0, 1 or 2 for sdr_width 00, 01 or 1x.
  - The internal address is APP_AW+2 bits wide.
- **Address map (internal address A, C = 8+cfg_colbits):**
  - caddr = A[C-1:0]
  - ba = A[C+BA_W-1:C]
  - raddr = A[C+BA_W+RA_W-1:C+BA_W]
- **State machine: IDLE → CALC → REQ.**
  - IDLE: if the queue is non-empty, pop the head into working registers (addr, rem, id, write, wrap), set first = 1, go to CALC.
  - CALC:
    - page_rem = 2^C − A[C-1:0], 13 bits.
    - If wrap, len = rem.
    - Otherwise len = min(rem, page_rem, CHUNK_MAX).
    - Register all r2b_* fields. r2b_start = first; r2b_last = (len == rem). Go to REQ.
  - REQ: r2b_req = 1 with all fields stable until b2r_ack.
    - On b2r_ack with last: go to IDLE.
    - On b2r_ack without last: addr += len, rem −= len, first = 0, go to CALC.
- **Zero length:** a popped entry with len 0 is discarded. No chunk is issued and the state returns to IDLE.
- **Wrap requests:** never split. Lengths beyond the page are the application's error and are passed through unchanged.
- **Width rules:**
  - Chunk arithmetic is unsigned.
  - Address addition wraps modulo 2^(APP_AW+2).
  - Row overflow is not flagged.
- **Idle:** r2x_idle = ~req & queue_empty & (state == IDLE).
- **Configuration:** cfg_colbits and sdr_width must be static while r2x_idle = 0. They are sampled at pop and CALC.

## Timing
- **Reset values:** state = IDLE, queue empty. All r2b_* outputs are 0, req_ack follows req, and r2x_idle = ~req.
- **Reset assertion:** aborts any in-flight split immediately and drops all queued entries.
- **Latency:** from a req_ack cycle to r2b_req high is 3 cycles when the block is empty (queue write, pop, CALC).
- **Between chunks:** b2r_ack in cycle n gives the next r2b_req in cycle n+2. r2b_req is low in cycle n+1.
- **Intake while REQ is stalled:** intake continues until QDEPTH entries are held. Then req_ack = 0 until the next pop.
- **Simultaneous push and pop on a full queue:** the push is not accepted. Full is evaluated before the pop.
- **Ordering:** chunks are issued strictly in request order. No chunks from different requests are interleaved.

## Test plan
- **16-bit page fit:** cfg_colbits = 00, sdr_width = 01, addr = 0x7C, len = 4, b2r_ack held high → one chunk with caddr = 0xF8, len = 8, ba = 0, start = 1, last = 1.
- **Page split:** same configuration, addr = 0x7E, len = 4 → chunk 1 with caddr = 0xFC, len = 4, ba = 0, start = 1, last = 0; then chunk 2 with caddr = 0x00, len = 4, ba = 1, start = 0, last = 1. Chunk 2 arrives 2 cycles after the ack of chunk 1.
- **CHUNK_MAX split:** CHUNK_MAX = 16, cfg_colbits = 11, sdr_width = 00, addr = 0, len = 40 → chunks of 16, 16 and 8 at caddr 0, 16 and 32; last = 1 only on the third.
- **Wrap:** wrap = 1, cfg_colbits = 00, sdr_width = 00, addr = 0xFC, len = 8 → one chunk with caddr = 0xFC, len = 8, wrap = 1, last = 1.
- **Queue backpressure:** QDEPTH = 2, b2r_ack = 0, three back-to-back reqs → the first two are acked, the third is held with req_ack = 0. The third is acked in the cycle after the first chunk's b2r_ack pops the next entry. Chunk IDs come out in request order.
- **Reset mid-split:** assert reset while in REQ of a 3-chunk request with 1 entry queued → outputs 0 immediately, r2x_idle = 1 after reset with req = 0, and no further chunks are issued.

Source files
------------

// File: rtl/sdrc_req_split_if.sv
// sdrc_req_split_if
//   Groups the application request channel and the bank-controller chunk
//   channel of sdrc_req_split.
//   slave  : view of the request splitter (consumes requests, issues chunks)
//   master : view of the environment (issues requests, accepts chunks)
//   Application side : req, req_id, req_addr, req_len, req_wr_n, req_wrap -> req_ack
//   Bank side        : r2b_* chunk fields with r2b_req valid <- b2r_ack
interface sdrc_req_split_if #(
  parameter int APP_AW = 30,
  parameter int APP_RW = 9,
  parameter int REQ_BW = 12,
  parameter int ID_W   = 4,
  parameter int BA_W   = 2,
  parameter int RA_W   = 13
);
  logic              req;
  logic [ID_W-1:0]   req_id;
  logic [APP_AW-1:0] req_addr;
  logic [APP_RW-1:0] req_len;
  logic              req_wr_n;
  logic              req_wrap;
  logic              req_ack;

  logic              r2b_req;
  logic [ID_W-1:0]   r2b_req_id;
  logic              r2b_start;
  logic              r2b_last;
  logic              r2b_wrap;
  logic              r2b_write;
  logic [BA_W-1:0]   r2b_ba;
  logic [RA_W-1:0]   r2b_raddr;
  logic [11:0]       r2b_caddr;
  logic [REQ_BW-1:0] r2b_len;
  logic              b2r_ack;

  modport slave (
    input  req, req_id, req_addr, req_len, req_wr_n, req_wrap, b2r_ack,
    output req_ack, r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap,
           r2b_write, r2b_ba, r2b_raddr, r2b_caddr, r2b_len
  );

  modport master (
    output req, req_id, req_addr, req_len, req_wr_n, req_wrap, b2r_ack,
    input  req_ack, r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap,
           r2b_write, r2b_ba, r2b_raddr, r2b_caddr, r2b_len
  );
endinterface

// File: rtl/sdrc_req_split.sv
// sdrc_req_split
//   Queues application requests, scales them to SDRAM beats for the
//   configured SDRAM width and splits each one into bank-controller chunks
//   that end at the page boundary (non-wrap) or at CHUNK_MAX beats.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   cfg_colbits  : column width = 8 + cfg_colbits
//   sdr_width    : 00 = 32-bit, 01 = 16-bit, 1x = 8-bit SDRAM
//   r2x_idle     : no request pending, queue empty, splitter idle
//   bus (slave)  : application request channel and bank chunk channel
module sdrc_req_split #(
  parameter int APP_AW    = 30,
  parameter int APP_RW    = 9,
  parameter int REQ_BW    = 12,
  parameter int ID_W      = 4,
  parameter int BA_W      = 2,
  parameter int RA_W      = 13,
  parameter int QDEPTH    = 2,
  parameter int CHUNK_MAX = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cfg_colbits,
  input  logic [1:0]       sdr_width,
  output logic             r2x_idle,
  sdrc_req_split_if.slave  bus
);
  localparam int IAW  = APP_AW + 2;
  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNTW = $clog2(QDEPTH + 1);
  localparam int EW   = ID_W + APP_AW + APP_RW + 2;
  localparam int CW   = (REQ_BW > 13) ? REQ_BW : 13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [1:0] width_shift(input logic [1:0] w);
    case (w)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // request queue
  logic [EW-1:0]   mem_q [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            q_full, q_empty, push, pop;

  logic [ID_W-1:0]   h_id;
  logic [APP_AW-1:0] h_addr;
  logic [APP_RW-1:0] h_len;
  logic              h_wr_n, h_wrap;
  logic [1:0]        sh;
  logic [IAW-1:0]    pop_addr;
  logic [REQ_BW-1:0] pop_len;

  // splitter state and working registers
  logic [1:0]        state_q, state_d;
  logic [IAW-1:0]    addr_q, addr_d;
  logic [REQ_BW-1:0] rem_q, rem_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              write_q, write_d, wrap_q, wrap_d, first_q, first_d;

  // registered chunk fields
  logic [ID_W-1:0]   r2b_id_q, r2b_id_d;
  logic              r2b_start_q, r2b_start_d, r2b_last_q, r2b_last_d;
  logic              r2b_wrap_q, r2b_wrap_d, r2b_write_q, r2b_write_d;
  logic [BA_W-1:0]   r2b_ba_q, r2b_ba_d;
  logic [RA_W-1:0]   r2b_raddr_q, r2b_raddr_d;
  logic [11:0]       r2b_caddr_q, r2b_caddr_d;
  logic [REQ_BW-1:0] r2b_len_q, r2b_len_d;

  // chunk calculation
  logic [3:0]        col_w;
  logic [11:0]       col;
  logic [12:0]       page_rem;
  logic [CW-1:0]     len_x;
  logic [REQ_BW-1:0] calc_len;

  assign q_full  = (cnt_q == CNTW'(QDEPTH));
  assign q_empty = (cnt_q == '0);
  // full is judged on the registered count, so a pop never frees a slot
  // for a push in the same cycle
  assign push    = bus.req & ~q_full;
  assign bus.req_ack = push;

  assign {h_id, h_addr, h_len, h_wr_n, h_wrap} = mem_q[rd_ptr_q];
  assign sh       = width_shift(sdr_width);
  assign pop_addr = {2'b00, h_addr} << sh;
  assign pop_len  = REQ_BW'(h_len) << sh;

  assign col_w    = 4'd8 + {2'b00, cfg_colbits};
  assign col      = addr_q[11:0] & ~(12'hFFF << col_w);
  assign page_rem = (13'd1 << col_w) - {1'b0, col};

  always_comb begin
    len_x = CW'(rem_q);
    if (!wrap_q) begin
      if (CW'(page_rem) < len_x) len_x = CW'(page_rem);
      if (CW'(CHUNK_MAX) < len_x) len_x = CW'(CHUNK_MAX);
    end
  end
  assign calc_len = REQ_BW'(len_x);

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    id_d        = id_q;
    write_d     = write_q;
    wrap_d      = wrap_q;
    first_d     = first_q;
    r2b_id_d    = r2b_id_q;
    r2b_start_d = r2b_start_q;
    r2b_last_d  = r2b_last_q;
    r2b_wrap_d  = r2b_wrap_q;
    r2b_write_d = r2b_write_q;
    r2b_ba_d    = r2b_ba_q;
    r2b_raddr_d = r2b_raddr_q;
    r2b_caddr_d = r2b_caddr_q;
    r2b_len_d   = r2b_len_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          addr_d  = pop_addr;
          rem_d   = pop_len;
          id_d    = h_id;
          write_d = ~h_wr_n;
          wrap_d  = h_wrap;
          first_d = 1'b1;
          // zero-length entries are consumed without issuing a chunk
          state_d = (pop_len == '0) ? ST_IDLE : ST_CALC;
        end
      end
      ST_CALC: begin
        r2b_id_d    = id_q;
        r2b_start_d = first_q;
        r2b_last_d  = (calc_len == rem_q);
        r2b_wrap_d  = wrap_q;
        r2b_write_d = write_q;
        r2b_ba_d    = BA_W'(addr_q >> col_w);
        r2b_raddr_d = RA_W'(addr_q >> ({1'b0, col_w} + 5'(BA_W)));
        r2b_caddr_d = col;
        r2b_len_d   = calc_len;
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        if (bus.b2r_ack) begin
          if (r2b_last_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + IAW'(r2b_len_q);
            rem_d   = rem_q - r2b_len_q;
            first_d = 1'b0;
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      r2b_id_q    <= '0;
      r2b_start_q <= 1'b0;
      r2b_last_q  <= 1'b0;
      r2b_wrap_q  <= 1'b0;
      r2b_write_q <= 1'b0;
      r2b_ba_q    <= '0;
      r2b_raddr_q <= '0;
      r2b_caddr_q <= '0;
      r2b_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      r2b_id_q    <= r2b_id_d;
      r2b_start_q <= r2b_start_d;
      r2b_last_q  <= r2b_last_d;
      r2b_wrap_q  <= r2b_wrap_d;
      r2b_write_q <= r2b_write_d;
      r2b_ba_q    <= r2b_ba_d;
      r2b_raddr_q <= r2b_raddr_d;
      r2b_caddr_q <= r2b_caddr_d;
      r2b_len_q   <= r2b_len_d;
    end
  end

  // datapath storage: only meaningful once loaded, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.req_id, bus.req_addr, bus.req_len, bus.req_wr_n, bus.req_wrap};
    addr_q  <= addr_d;
    rem_q   <= rem_d;
    id_q    <= id_d;
    write_q <= write_d;
    wrap_q  <= wrap_d;
  end

  assign r2x_idle       = ~bus.req & q_empty & (state_q == ST_IDLE);
  assign bus.r2b_req    = (state_q == ST_REQ);
  assign bus.r2b_req_id = r2b_id_q;
  assign bus.r2b_start  = r2b_start_q;
  assign bus.r2b_last   = r2b_last_q;
  assign bus.r2b_wrap   = r2b_wrap_q;
  assign bus.r2b_write  = r2b_write_q;
  assign bus.r2b_ba     = r2b_ba_q;
  assign bus.r2b_raddr  = r2b_raddr_q;
  assign bus.r2b_caddr  = r2b_caddr_q;
  assign bus.r2b_len    = r2b_len_q;
endmodule

// File: tb/tb_sdrc_req_split.sv
// tb_sdrc_req_split
//   Directed bench for sdrc_req_split: reset state, page fit, page split,
//   CHUNK_MAX split, wrap, zero length, queue backpressure and reset in the
//   middle of a split.
module tb_sdrc_req_split;
  localparam int APP_AW = 30, APP_RW = 9, REQ_BW = 12, ID_W = 4;
  localparam int BA_W = 2, RA_W = 13, QDEPTH = 2, CHUNK_MAX = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cfg_colbits, sdr_width;
  logic       r2x_idle;
  int         n_tests = 0;
  int         n_fail  = 0;

  sdrc_req_split_if #(.APP_AW(APP_AW), .APP_RW(APP_RW), .REQ_BW(REQ_BW),
                      .ID_W(ID_W), .BA_W(BA_W), .RA_W(RA_W)) bus ();

  sdrc_req_split #(.APP_AW(APP_AW), .APP_RW(APP_RW), .REQ_BW(REQ_BW), .ID_W(ID_W),
                   .BA_W(BA_W), .RA_W(RA_W), .QDEPTH(QDEPTH), .CHUNK_MAX(CHUNK_MAX)) dut (
    .clk(clk), .reset(reset), .cfg_colbits(cfg_colbits), .sdr_width(sdr_width),
    .r2x_idle(r2x_idle), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic [ID_W-1:0] id, input logic [APP_AW-1:0] addr,
                         input logic [APP_RW-1:0] len, input logic wr_n, input logic wrap);
    bus.req_id = id; bus.req_addr = addr; bus.req_len = len;
    bus.req_wr_n = wr_n; bus.req_wrap = wrap; bus.req = 1'b1;
  endtask

  // one-cycle request into a queue known to have room
  task automatic push(input logic [ID_W-1:0] id, input logic [APP_AW-1:0] addr,
                      input logic [APP_RW-1:0] len, input logic wr_n, input logic wrap);
    @(posedge clk); #1;
    set_req(id, addr, len, wr_n, wrap);
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  // waits at falling edges until a chunk is presented; cyc = empty edges seen
  task automatic wait_chunk(input int max_cyc, output int cyc, output bit got);
    got = 1'b0; cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge clk);
      if (bus.r2b_req === 1'b1) got = 1'b1;
      else cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req = 1'b0; bus.b2r_ack = 1'b0;
    bus.req_id = '0; bus.req_addr = '0; bus.req_len = '0; bus.req_wr_n = 1'b1; bus.req_wrap = 1'b0;
    cfg_colbits = 2'b00; sdr_width = 2'b00;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.r2b_req !== 1'b0) begin n_fail++; $display("FAIL reset_r2b_req got %b want 0", bus.r2b_req); end
    n_tests++; if (bus.r2b_len !== 12'd0 || bus.r2b_caddr !== 12'd0 || bus.r2b_req_id !== 4'd0) begin
      n_fail++; $display("FAIL reset_fields got len=%0d caddr=%0h id=%0d want 0", bus.r2b_len, bus.r2b_caddr, bus.r2b_req_id); end
    n_tests++; if (r2x_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", r2x_idle); end
    bus.req = 1'b1; #1;
    n_tests++; if (bus.req_ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack_follows_req got %b want 1", bus.req_ack); end
    n_tests++; if (r2x_idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req got %b want 0", r2x_idle); end
    bus.req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_page_fit();
    int cyc; bit got;
    cfg_colbits = 2'b00; sdr_width = 2'b01; bus.b2r_ack = 1'b1;
    push(4'd1, 30'h7C, 9'd4, 1'b1, 1'b0);
    wait_chunk(10, cyc, got);
    n_tests++; if (!got) begin n_fail++; $display("FAIL fit_chunk got none want chunk"); end
    n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL fit_latency got %0d idle edges want 2", cyc); end
    n_tests++; if (bus.r2b_caddr !== 12'hF8 || bus.r2b_len !== 12'd8 || bus.r2b_ba !== 2'd0) begin
      n_fail++; $display("FAIL fit_fields got caddr=%0h len=%0d ba=%0d want F8 8 0", bus.r2b_caddr, bus.r2b_len, bus.r2b_ba); end
    n_tests++; if (bus.r2b_start !== 1'b1 || bus.r2b_last !== 1'b1 || bus.r2b_write !== 1'b0 || bus.r2b_req_id !== 4'd1) begin
      n_fail++; $display("FAIL fit_flags got start=%b last=%b write=%b id=%0d want 1 1 0 1",
                         bus.r2b_start, bus.r2b_last, bus.r2b_write, bus.r2b_req_id); end
    @(negedge clk);
    n_tests++; if (bus.r2b_req !== 1'b0) begin n_fail++; $display("FAIL fit_single got r2b_req=%b want 0", bus.r2b_req); end
  endtask

  task automatic test_page_split();
    int cyc; bit got;
    cfg_colbits = 2'b00; sdr_width = 2'b01; bus.b2r_ack = 1'b1;
    push(4'd2, 30'h7E, 9'd4, 1'b1, 1'b0);
    wait_chunk(10, cyc, got);
    n_tests++; if (!got || bus.r2b_caddr !== 12'hFC || bus.r2b_len !== 12'd4 || bus.r2b_ba !== 2'd0) begin
      n_fail++; $display("FAIL split_c1 got req=%b caddr=%0h len=%0d ba=%0d want 1 FC 4 0", got, bus.r2b_caddr, bus.r2b_len, bus.r2b_ba); end
    n_tests++; if (bus.r2b_start !== 1'b1 || bus.r2b_last !== 1'b0) begin
      n_fail++; $display("FAIL split_c1_flags got start=%b last=%b want 1 0", bus.r2b_start, bus.r2b_last); end
    @(negedge clk);
    n_tests++; if (bus.r2b_req !== 1'b0) begin n_fail++; $display("FAIL split_gap got r2b_req=%b want 0", bus.r2b_req); end
    @(negedge clk);
    n_tests++; if (bus.r2b_req !== 1'b1 || bus.r2b_caddr !== 12'h00 || bus.r2b_len !== 12'd4 || bus.r2b_ba !== 2'd1) begin
      n_fail++; $display("FAIL split_c2 got req=%b caddr=%0h len=%0d ba=%0d want 1 0 4 1", bus.r2b_req, bus.r2b_caddr, bus.r2b_len, bus.r2b_ba); end
    n_tests++; if (bus.r2b_start !== 1'b0 || bus.r2b_last !== 1'b1) begin
      n_fail++; $display("FAIL split_c2_flags got start=%b last=%b want 0 1", bus.r2b_start, bus.r2b_last); end
    @(negedge clk);
  endtask

  task automatic test_chunk_max();
    int cyc; bit got;
    logic [11:0] exp_len [3];
    logic [11:0] exp_col [3];
    exp_len[0] = 12'd16; exp_len[1] = 12'd16; exp_len[2] = 12'd8;
    exp_col[0] = 12'd0;  exp_col[1] = 12'd16; exp_col[2] = 12'd32;
    cfg_colbits = 2'b11; sdr_width = 2'b00; bus.b2r_ack = 1'b1;
    push(4'd3, 30'h0, 9'd40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_chunk(10, cyc, got);
      n_tests++; if (!got || bus.r2b_len !== exp_len[i] || bus.r2b_caddr !== exp_col[i]) begin
        n_fail++; $display("FAIL cmax_c%0d got req=%b len=%0d caddr=%0d want 1 %0d %0d",
                           i, got, bus.r2b_len, bus.r2b_caddr, exp_len[i], exp_col[i]); end
      n_tests++; if (bus.r2b_last !== (i == 2) || bus.r2b_write !== 1'b1) begin
        n_fail++; $display("FAIL cmax_flags%0d got last=%b write=%b want %b 1", i, bus.r2b_last, bus.r2b_write, (i == 2)); end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int cyc; bit got;
    cfg_colbits = 2'b00; sdr_width = 2'b00; bus.b2r_ack = 1'b1;
    push(4'd4, 30'hFC, 9'd8, 1'b0, 1'b1);
    wait_chunk(10, cyc, got);
    n_tests++; if (!got || bus.r2b_caddr !== 12'hFC || bus.r2b_len !== 12'd8) begin
      n_fail++; $display("FAIL wrap_chunk got req=%b caddr=%0h len=%0d want 1 FC 8", got, bus.r2b_caddr, bus.r2b_len); end
    n_tests++; if (bus.r2b_wrap !== 1'b1 || bus.r2b_last !== 1'b1 || bus.r2b_start !== 1'b1) begin
      n_fail++; $display("FAIL wrap_flags got wrap=%b last=%b start=%b want 1 1 1", bus.r2b_wrap, bus.r2b_last, bus.r2b_start); end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    bit seen;
    seen = 1'b0; bus.b2r_ack = 1'b1;
    push(4'd5, 30'h20, 9'd0, 1'b1, 1'b0);
    repeat (6) begin @(negedge clk); if (bus.r2b_req === 1'b1) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL zero_len got chunk=%b want 0", seen); end
    n_tests++; if (r2x_idle !== 1'b1) begin n_fail++; $display("FAIL zero_idle got %b want 1", r2x_idle); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit got;
    logic [3:0] exp_id [3];
    exp_id[0] = 4'd7; exp_id[1] = 4'd8; exp_id[2] = 4'd9;
    cfg_colbits = 2'b00; sdr_width = 2'b00; bus.b2r_ack = 1'b0;
    push(4'd6, 30'h10, 9'd4, 1'b1, 1'b0);
    wait_chunk(10, cyc, got);
    n_tests++; if (!got || bus.r2b_req_id !== 4'd6) begin n_fail++; $display("FAIL bp_first got req=%b id=%0d want 1 6", got, bus.r2b_req_id); end
    @(posedge clk); #1 set_req(4'd7, 30'h10, 9'd4, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.req_ack !== 1'b1) begin n_fail++; $display("FAIL bp_ack1 got %b want 1", bus.req_ack); end
    @(posedge clk); #1 set_req(4'd8, 30'h10, 9'd4, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.req_ack !== 1'b1) begin n_fail++; $display("FAIL bp_ack2 got %b want 1", bus.req_ack); end
    @(posedge clk); #1 set_req(4'd9, 30'h10, 9'd4, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b want 0", bus.req_ack); end
    @(negedge clk);
    n_tests++; if (bus.req_ack !== 1'b0 || r2x_idle !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold got ack=%b idle=%b want 0 0", bus.req_ack, r2x_idle); end
    @(posedge clk); #1 bus.b2r_ack = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL bp_ackcyc got %b want 0", bus.req_ack); end
    @(posedge clk); #1 bus.b2r_ack = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.req_ack !== 1'b0 || bus.r2b_req !== 1'b0) begin
      n_fail++; $display("FAIL bp_popcyc got ack=%b r2b_req=%b want 0 0", bus.req_ack, bus.r2b_req); end
    @(negedge clk);
    n_tests++; if (bus.req_ack !== 1'b1) begin n_fail++; $display("FAIL bp_third_ack got %b want 1", bus.req_ack); end
    @(posedge clk); #1 bus.req = 1'b0; bus.b2r_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_chunk(12, cyc, got);
      n_tests++; if (!got || bus.r2b_req_id !== exp_id[i]) begin
        n_fail++; $display("FAIL bp_order%0d got req=%b id=%0d want 1 %0d", i, got, bus.r2b_req_id, exp_id[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_split();
    int cyc; bit got, seen;
    seen = 1'b0;
    cfg_colbits = 2'b11; sdr_width = 2'b00; bus.b2r_ack = 1'b0;
    push(4'd10, 30'h0, 9'd40, 1'b1, 1'b0);
    wait_chunk(10, cyc, got);
    n_tests++; if (!got || bus.r2b_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre got req=%b last=%b want 1 0", got, bus.r2b_last); end
    push(4'd11, 30'h40, 9'd2, 1'b1, 1'b0);
    @(negedge clk); #2 reset = 1'b1; #1;
    n_tests++; if (bus.r2b_req !== 1'b0 || bus.r2b_len !== 12'd0 || bus.r2b_req_id !== 4'd0 || bus.r2b_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got req=%b len=%0d id=%0d start=%b want 0 0 0 0",
                         bus.r2b_req, bus.r2b_len, bus.r2b_req_id, bus.r2b_start); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (r2x_idle !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle got %b want 1", r2x_idle); end
    bus.b2r_ack = 1'b1;
    repeat (12) begin @(negedge clk); if (bus.r2b_req === 1'b1) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_chunk got chunk=%b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_page_fit();
    test_page_split();
    test_chunk_max();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_split();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
